// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants and types for the frame-buffer arbiter
package fb_pkg;

    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_SCALE  = 2;
    localparam int DEF_DATA_W = 12;

    localparam int FB_W      = DEF_H_RES >> DEF_SCALE;
    localparam int FB_H      = DEF_V_RES >> DEF_SCALE;
    localparam int FB_DEPTH  = FB_W * FB_H;
    localparam int FB_ADDR_W = $clog2(FB_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        RDATA = 1'b1
    } arb_state_t;

    function automatic int fb_depth(input int h_res, input int v_res, input int scale);
        return (h_res >> scale) * (v_res >> scale);
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// rtl/fb_addr_gen.sv - screen coordinate to downscaled frame-buffer address
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int SCALE  = DEF_SCALE,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_RES >> SCALE);
    localparam logic [9:0]        H_LIM      = 10'(H_RES);
    localparam logic [9:0]        V_LIM      = 10'(V_RES);

    logic [9:0] col;
    logic [9:0] row;

    always_comb begin
        col      = pixel_x >> SCALE;
        row      = pixel_y >> SCALE;
        addr     = ADDR_W'(row) * ROW_STRIDE + ADDR_W'(col);
        in_range = (pixel_x < H_LIM) && (pixel_y < V_LIM);
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port frame-buffer arbiter, VGA scan-out over CPU access
module vga_fb_arbiter
    import fb_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int SCALE  = DEF_SCALE,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [DATA_W-1:0] vga_rgb,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int            DEPTH   = fb_depth(H_RES, V_RES, SCALE);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_in_range;
    logic              vga_req;
    logic              cpu_in_range;
    logic              grant;
    logic              vga_slot_q;
    logic              vga_live_q;
    logic              rd_live_q;

    fb_addr_gen #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .SCALE  (SCALE),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .addr     (vga_addr),
        .in_range (vga_in_range)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Combinational outputs are held low while reset is asserted so the BRAM sees no access.
    always_comb begin
        state_d      = state_q;
        vga_req      = pix_en && video_on && vga_in_range;
        cpu_in_range = {1'b0, cpu_addr} < DEPTH_C;
        grant        = !reset && !pix_en && (state_q == IDLE) && cpu_valid;
        cpu_ready    = grant;
        mem_en       = !reset && (vga_req || (grant && cpu_in_range));
        mem_we       = !reset && grant && cpu_we && cpu_in_range;
        mem_addr     = pix_en ? vga_addr : cpu_addr;
        mem_wdata    = cpu_wdata;

        case (state_q)
            IDLE:    if (grant && !cpu_we) state_d = RDATA;
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Each read's data lands in the cycle after its own issue, so VGA and CPU captures never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_slot_q <= 1'b0;
            vga_live_q <= 1'b0;
            vga_rgb    <= '0;
            rd_live_q  <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            vga_slot_q <= pix_en;
            vga_live_q <= vga_req;
            if (vga_slot_q) begin
                vga_rgb <= vga_live_q ? mem_rdata : '0;
            end

            if (grant && !cpu_we) begin
                rd_live_q <= cpu_in_range;
            end
            cpu_rvalid <= (state_q == RDATA);
            if (state_q == RDATA) begin
                cpu_rdata <= rd_live_q ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 19200;

    logic              clk = 1'b0;
    logic              reset;
    logic              pix_en;
    logic              video_on;
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic [DATA_W-1:0] vga_rgb;
    logic              cpu_valid;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .vga_rgb    (vga_rgb),
        .cpu_valid  (cpu_valid),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[161]   = 12'hABC;
        mem[19199] = 12'h7E1;
        mem[2]     = 12'h456;
        mem[32]    = 12'h123;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                mem_rdata <= mem[mem_addr];
                if (mem_we) mem[mem_addr] <= mem_wdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
        cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        repeat (2) @(negedge clk);
        pix_en = 1'b1; video_on = 1'b1; pixel_x = 10'd4; pixel_y = 10'd4;
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h10;
        #1;
        chk("rst_vga_rgb", 32'(vga_rgb), 32'h0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);

        @(negedge clk);
        reset = 1'b0; pix_en = 1'b0; video_on = 1'b0; cpu_valid = 1'b0;
        repeat (2) @(negedge clk);

        // VGA slot at (4,4) -> address 161
        pix_en = 1'b1; video_on = 1'b1; pixel_x = 10'd4; pixel_y = 10'd4;
        #1;
        chk("vga_mem_en", 32'(mem_en), 32'h1);
        chk("vga_mem_we", 32'(mem_we), 32'h0);
        chk("vga_mem_addr", 32'(mem_addr), 32'd161);
        @(negedge clk); pix_en = 1'b0; #1;
        chk("vga_rgb_t1", 32'(vga_rgb), 32'h0);
        @(negedge clk); #1;
        chk("vga_rgb_t2", 32'(vga_rgb), 32'hABC);
        @(negedge clk);

        // blanked slot
        @(negedge clk); pix_en = 1'b1; video_on = 1'b0; #1;
        chk("blank_mem_en", 32'(mem_en), 32'h0);
        @(negedge clk); pix_en = 1'b0;
        @(negedge clk); #1;
        chk("blank_rgb", 32'(vga_rgb), 32'h0);
        @(negedge clk);

        // last pixel of the frame -> last word
        @(negedge clk); pix_en = 1'b1; video_on = 1'b1; pixel_x = 10'd639; pixel_y = 10'd479; #1;
        chk("corner_mem_en", 32'(mem_en), 32'h1);
        chk("corner_mem_addr", 32'(mem_addr), 32'd19199);
        @(negedge clk); pix_en = 1'b0;
        @(negedge clk); #1;
        chk("corner_rgb", 32'(vga_rgb), 32'h7E1);
        @(negedge clk);

        // x beyond active width with video_on high
        @(negedge clk); pix_en = 1'b1; pixel_x = 10'd640; pixel_y = 10'd0; #1;
        chk("xoor_mem_en", 32'(mem_en), 32'h0);
        @(negedge clk); pix_en = 1'b0;
        @(negedge clk); #1;
        chk("xoor_rgb", 32'(vga_rgb), 32'h0);
        @(negedge clk);

        // CPU write raised on a pixel strobe
        @(negedge clk);
        pix_en = 1'b1; video_on = 1'b0;
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h10; cpu_wdata = 12'h5A5;
        #1;
        chk("wr_wait_ready", 32'(cpu_ready), 32'h0);
        chk("wr_wait_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk); pix_en = 1'b0; #1;
        chk("wr_ready", 32'(cpu_ready), 32'h1);
        chk("wr_mem_en", 32'(mem_en), 32'h1);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h10);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h5A5);
        @(negedge clk); cpu_valid = 1'b0; #1;
        chk("wr_done_mem_en", 32'(mem_en), 32'h0);

        // read back, with a write request held during RDATA
        @(negedge clk); cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h10; #1;
        chk("rd_ready", 32'(cpu_ready), 32'h1);
        chk("rd_mem_en", 32'(mem_en), 32'h1);
        chk("rd_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk); cpu_we = 1'b1; cpu_addr = 15'h11; cpu_wdata = 12'h111; #1;
        chk("rdata_state_ready", 32'(cpu_ready), 32'h0);
        chk("rdata_state_mem_en", 32'(mem_en), 32'h0);
        chk("rd_rvalid_t1", 32'(cpu_rvalid), 32'h0);
        @(negedge clk); #1;
        chk("rd_rvalid_t2", 32'(cpu_rvalid), 32'h1);
        chk("rd_rdata", 32'(cpu_rdata), 32'h5A5);
        chk("wr2_ready", 32'(cpu_ready), 32'h1);
        @(negedge clk); cpu_valid = 1'b0; #1;
        chk("rd_rvalid_single", 32'(cpu_rvalid), 32'h0);

        // CPU read granted the cycle before a VGA slot
        @(negedge clk); cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h20; #1;
        chk("mix_rd_ready", 32'(cpu_ready), 32'h1);
        @(negedge clk);
        cpu_valid = 1'b0; pix_en = 1'b1; video_on = 1'b1; pixel_x = 10'd8; pixel_y = 10'd0;
        #1;
        chk("mix_vga_mem_en", 32'(mem_en), 32'h1);
        chk("mix_vga_mem_addr", 32'(mem_addr), 32'd2);
        @(negedge clk); pix_en = 1'b0; #1;
        chk("mix_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("mix_rdata", 32'(cpu_rdata), 32'h123);
        chk("mix_rgb_old", 32'(vga_rgb), 32'h0);
        @(negedge clk); #1;
        chk("mix_rgb_new", 32'(vga_rgb), 32'h456);
        chk("mix_rvalid_single", 32'(cpu_rvalid), 32'h0);

        // out-of-range CPU address
        @(negedge clk); cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd19200; cpu_wdata = 12'hFFF; #1;
        chk("oor_wr_ready", 32'(cpu_ready), 32'h1);
        chk("oor_wr_mem_en", 32'(mem_en), 32'h0);
        chk("oor_wr_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk); cpu_we = 1'b0; #1;
        chk("oor_rd_ready", 32'(cpu_ready), 32'h1);
        chk("oor_rd_mem_en", 32'(mem_en), 32'h0);
        @(negedge clk); cpu_valid = 1'b0; #1;
        chk("oor_rvalid_t1", 32'(cpu_rvalid), 32'h0);
        @(negedge clk); #1;
        chk("oor_rvalid_t2", 32'(cpu_rvalid), 32'h1);
        chk("oor_rdata", 32'(cpu_rdata), 32'h0);

        // reset in the cycle after a read grant
        @(negedge clk); cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h10; #1;
        chk("rst_rd_ready", 32'(cpu_ready), 32'h1);
        @(negedge clk); cpu_valid = 1'b0; reset = 1'b1; #1;
        chk("midrst_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("midrst_rgb", 32'(vga_rgb), 32'h0);
        chk("midrst_rdata", 32'(cpu_rdata), 32'h0);
        chk("midrst_mem_en", 32'(mem_en), 32'h0);
        @(negedge clk); #1;
        chk("midrst_rvalid_t2", 32'(cpu_rvalid), 32'h0);
        @(negedge clk); reset = 1'b0; #1;
        chk("postrst_rvalid_t3", 32'(cpu_rvalid), 32'h0);
        @(negedge clk); #1;
        chk("postrst_rvalid_t4", 32'(cpu_rvalid), 32'h0);

        // normal operation after release
        @(negedge clk); pix_en = 1'b1; video_on = 1'b1; pixel_x = 10'd4; pixel_y = 10'd4;
        @(negedge clk); pix_en = 1'b0; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h10; #1;
        chk("post_rd_ready", 32'(cpu_ready), 32'h1);
        @(negedge clk); cpu_valid = 1'b0; #1;
        chk("post_rgb", 32'(vga_rgb), 32'hABC);
        @(negedge clk); #1;
        chk("post_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("post_rdata", 32'(cpu_rdata), 32'h5A5);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
